// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared types and constants for logic_unit and its pipeline wrapper.
//   LU_WIDTH        operand/result width (fixed)
//   LU_AND..LU_NOT  opcodes
//   lu_op_t         2-bit opcode type
//   lu_req_t        stage-1 command (a, b, op)
//   lu_rsp_t        stage-2 result (res, op, zero)
//   stage_st_t      per-stage occupancy state
package logic_unit_pkg;
  localparam int LU_WIDTH = 4;

  typedef logic [1:0] lu_op_t;

  localparam lu_op_t LU_AND = 2'b00;
  localparam lu_op_t LU_OR  = 2'b01;
  localparam lu_op_t LU_XOR = 2'b10;
  localparam lu_op_t LU_NOT = 2'b11;

  typedef struct packed {
    logic [LU_WIDTH-1:0] a;
    logic [LU_WIDTH-1:0] b;
    lu_op_t              op;
  } lu_req_t;

  typedef struct packed {
    logic [LU_WIDTH-1:0] res;
    lu_op_t              op;
    logic                zero;
  } lu_rsp_t;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_st_t;
endpackage

// File: rtl/logic_unit.sv
// logic_unit: combinational 4-bit AND/OR/XOR/NOT.
//   a, b  operands (b unused for NOT)
//   op    opcode (lu_op_t)
//   y     result
module logic_unit
  import logic_unit_pkg::*;
(
  input  logic [LU_WIDTH-1:0] a,
  input  logic [LU_WIDTH-1:0] b,
  input  lu_op_t              op,
  output logic [LU_WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      LU_AND:  y = a & b;
      LU_OR:   y = a | b;
      LU_XOR:  y = a ^ b;
      default: y = ~a;
    endcase
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready wrapper around logic_unit.
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           command handshake; in_a, in_b, in_op payload
//   out_valid/out_ready         result handshake; out_result, out_op, out_zero payload
//   done_count                  wrapping count of output handshakes
// Stage 1 registers the command and drives logic_unit; stage 2 registers the
// result. The only combinational path is out_ready -> in_ready.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_op,
  output logic             out_zero,
  output logic [CNT_W-1:0] done_count
);
  // logic_unit is hard-wired to LU_WIDTH; refuse any other configuration.
  if (WIDTH != LU_WIDTH) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must equal LU_WIDTH");
  end

  stage_st_t            s1_st_q, s1_st_d, s2_st_q, s2_st_d;
  lu_req_t              s1_q, s1_d;
  lu_rsp_t              s2_q, s2_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LU_WIDTH-1:0]  lu_y;
  logic                 s1_valid, s2_valid, s2_free;

  logic_unit u_lu (
    .a  (s1_q.a),
    .b  (s1_q.b),
    .op (s1_q.op),
    .y  (lu_y)
  );

  assign s1_valid = (s1_st_q == ST_FULL);
  assign s2_valid = (s2_st_q == ST_FULL);
  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;

  always_comb begin
    s1_st_d = s1_st_q;
    s1_d    = s1_q;
    s2_st_d = s2_st_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;

    // Stage 2: load from stage 1 or drain to empty; data held when empty
    // so out_* only change on a real load.
    if (s2_free) begin
      if (s1_valid) begin
        s2_st_d = ST_FULL;
        s2_d    = '{res: lu_y, op: s1_q.op, zero: (lu_y == '0)};
      end else begin
        s2_st_d = ST_EMPTY;
      end
    end

    // Stage 1: in_ready means stage 1 is empty or moves on this edge.
    if (in_ready) begin
      if (in_valid) begin
        s1_st_d = ST_FULL;
        s1_d    = '{a: in_a, b: in_b, op: lu_op_t'(in_op)};
      end else begin
        s1_st_d = ST_EMPTY;
      end
    end

    if (out_valid && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_st_q <= ST_EMPTY;
      s1_q    <= '0;
      s2_st_q <= ST_EMPTY;
      s2_q    <= '0;
      cnt_q   <= '0;
    end else begin
      s1_st_q <= s1_st_d;
      s1_q    <= s1_d;
      s2_st_q <= s2_st_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_q.res;
  assign out_op     = s2_q.op;
  assign out_zero   = s2_q.zero;
  assign done_count = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
  logic       clk = 0, rst_n = 0;
  logic       in_valid = 0, in_ready;
  logic [3:0] in_a = 0, in_b = 0;
  logic [1:0] in_op = 0;
  logic       out_valid, out_ready = 0;
  logic [3:0] out_result;
  logic [1:0] out_op;
  logic       out_zero;
  logic [7:0] done_count;

  logic_unit_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .done_count(done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic [1:0] op;
    logic       zero;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  int   exp_done = 0;
  bit   chk_lat = 0;
  bit   rand_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] ref_lu(input logic [3:0] a, b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] a, b, input logic [1:0] op, input int acc);
    exp_t e;
    e.res  = ref_lu(a, b, op);
    e.op   = op;
    e.zero = (e.res == 4'd0);
    e.acc  = acc;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure during the soak run.
  always @(posedge clk) if (rand_rdy) begin
    #1 if (rand_rdy) out_ready = 1'($urandom);
  end

  // Output monitor: transfer happens at the coming edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_op", out_op, e.op);
        chk("out_zero", out_zero, e.zero);
        if (chk_lat) chk("latency", cyc, e.acc + 1);
        exp_done++;
      end
    end
  end

  // Drive one command; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] a, b, input logic [1:0] op);
    bit done = 0;
    in_valid = 1; in_a = a; in_b = b; in_op = op;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(mk_exp(a, b, op, cyc + 1));
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] hold_res;
    logic [1:0] hold_op;
    logic [3:0] ra, rb;
    logic [1:0] rop;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_zero", out_zero, 0);
    @(posedge clk); #1 rst_n = 1;

    // Streaming with latency check
    out_ready = 1; chk_lat = 1;
    send(4'b1100, 4'b1010, 2'b00);
    send(4'b1100, 4'b1010, 2'b01);
    send(4'b1100, 4'b1010, 2'b10);
    send(4'b1100, 4'b1010, 2'b11);
    drain();
    chk_lat = 0;
    chk("stream_done_count", done_count, 4);

    // Backpressure: only two fit
    out_ready = 0;
    send(4'b1100, 4'b1010, 2'b00);
    send(4'b0011, 4'b0101, 2'b01);
    in_valid = 1; in_a = 4'b1111; in_b = 4'b0001; in_op = 2'b10;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    hold_res = out_result; hold_op = out_op;
    chk("bp_head_result", out_result, 4'b1000);
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready_hold", in_ready, 0);
      chk("bp_stable_result", out_result, hold_res);
      chk("bp_stable_op", out_op, hold_op);
    end
    @(posedge clk); #1 out_ready = 1;
    in_valid = 0;
    send(4'b1111, 4'b0001, 2'b10);
    drain();
    chk("bp_done_count", done_count, 7);

    // Zero flag and NOT ignoring B
    send(4'b0101, 4'b1010, 2'b00);
    send(4'b1111, 4'b0000, 2'b11);
    send(4'b0000, 4'b0001, 2'b01);
    send(4'b0110, 4'b0000, 2'b11);
    send(4'b0110, 4'b1111, 2'b11);
    drain();
    chk("misc_done_count", done_count, exp_done[7:0]);

    // Mid-stream reset discards in-flight commands
    out_ready = 0;
    send(4'b1010, 4'b0101, 2'b01);
    send(4'b1010, 4'b0101, 2'b10);
    #2 rst_n = 0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_done_count", done_count, 0);
    @(posedge clk); #1 rst_n = 1; out_ready = 1; exp_done = 0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_out", out_valid, 0);
    end
    @(posedge clk); #1;

    // 256 random commands with random backpressure; counter wraps to 0
    rand_rdy = 1;
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rop = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(ra, rb, rop);
    end
    rand_rdy = 0;
    @(posedge clk); #2 out_ready = 1;
    drain();
    chk("rand_count", exp_done, 256);
    chk("wrap_done_count", done_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
